// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: walks non-overlapping POOLxPOOL windows of a row-major map, driving an external running-max accumulator and streaming one pooled value per window.
module maxpool_ctrl #(
  parameter int N          = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int POOL       = 2,
  parameter int ADDR_W     = 10,
  parameter int OUT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic signed [N-1:0]   rd_data,
  output logic                  acc_clr,
  output logic                  acc_valid,
  output logic signed [N-1:0]   acc_din,
  input  logic signed [N-1:0]   acc_max,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [N-1:0]   out_data,
  output logic [OUT_ADDR_W-1:0] out_addr
);
  localparam int OUT_W = IMG_W / POOL;
  localparam int OUT_H = IMG_H / POOL;
  typedef enum logic [2:0] {IDLE, CLR, READ, WAIT1, WAIT2, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wx_q, wx_d, wy_q, wy_d, dx_q, dx_d, dy_q, dy_d;
  logic signed [N-1:0] out_data_q, out_data_d;
  logic [OUT_ADDR_W-1:0] out_addr_q, out_addr_d;
  logic acc_valid_q, acc_valid_d;
  logic last_dx, last_px, last_wx, last_win;
  always_comb begin
    last_dx    = dx_q == ADDR_W'(POOL - 1);
    last_px    = last_dx && dy_q == ADDR_W'(POOL - 1);
    last_wx    = wx_q == ADDR_W'(OUT_W - 1);
    last_win   = last_wx && wy_q == ADDR_W'(OUT_H - 1);
    state_d    = state_q;
    wx_d       = wx_q;
    wy_d       = wy_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    case (state_q)
      IDLE: if (start) begin
        wx_d    = '0;
        wy_d    = '0;
        dx_d    = '0;
        dy_d    = '0;
        state_d = CLR;
      end
      CLR:   state_d = READ;
      READ: begin
        dx_d    = last_dx ? '0 : dx_q + ADDR_W'(1);
        dy_d    = !last_dx ? dy_q : last_px ? '0 : dy_q + ADDR_W'(1);
        state_d = last_px ? WAIT1 : READ;
      end
      WAIT1: state_d = WAIT2;
      WAIT2: begin
        out_data_d = acc_max;
        out_addr_d = OUT_ADDR_W'(32'(wy_q) * OUT_W + 32'(wx_q));
        state_d    = EMIT;
      end
      EMIT: if (out_ready) begin
        wx_d    = last_wx ? '0 : wx_q + ADDR_W'(1);
        wy_d    = last_wx ? wy_q + ADDR_W'(1) : wy_q;
        state_d = last_win ? DONE : CLR;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign rd_en       = state_q == READ;
  assign rd_addr     = rd_en ? ADDR_W'((32'(wy_q) * POOL + 32'(dy_q)) * IMG_W + 32'(wx_q) * POOL + 32'(dx_q)) : '0;
  assign acc_valid_d = rd_en;
  assign acc_clr     = state_q == CLR;
  assign acc_valid   = acc_valid_q;
  assign acc_din     = rd_data;
  assign busy        = state_q inside {CLR, READ, WAIT1, WAIT2, EMIT};
  assign done        = state_q == DONE;
  assign out_valid   = state_q == EMIT;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wx_q        <= '0;
      wy_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      acc_valid_q <= acc_valid_d;
    end
  end
endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb_maxpool_ctrl: runs a 4x4 and a 5x5 instance side by side against a window-max reference model.
module tb_maxpool_ctrl;
  localparam int N = 16;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  always #5 clk = ~clk;

  logic a_busy, a_done, a_rd_en, a_clr, a_av, a_ov;
  logic b_busy, b_done, b_rd_en, b_clr, b_av, b_ov;
  logic [9:0] a_ra, b_ra;
  logic [7:0] a_oa, b_oa;
  logic signed [N-1:0] a_rd = '0, b_rd = '0, a_mx = '0, b_mx = '0;
  logic signed [N-1:0] a_din, b_din, a_od, b_od;
  logic signed [N-1:0] mem [2][25];

  maxpool_ctrl #(.N(N), .IMG_W(4), .IMG_H(4), .POOL(2), .ADDR_W(10), .OUT_ADDR_W(8)) u_a (
    .clk(clk), .reset(reset), .start(start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_ra), .rd_data(a_rd), .acc_clr(a_clr), .acc_valid(a_av),
    .acc_din(a_din), .acc_max(a_mx), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_od), .out_addr(a_oa));
  maxpool_ctrl #(.N(N), .IMG_W(5), .IMG_H(5), .POOL(2), .ADDR_W(10), .OUT_ADDR_W(8)) u_b (
    .clk(clk), .reset(reset), .start(start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_ra), .rd_data(b_rd), .acc_clr(b_clr), .acc_valid(b_av),
    .acc_din(b_din), .acc_max(b_mx), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_od), .out_addr(b_oa));

  // Environment: 1-cycle buffer memory and running-max accumulator per instance.
  always @(posedge clk) begin
    if (a_rd_en) a_rd <= mem[0][int'(a_ra) % 25];
    if (b_rd_en) b_rd <= mem[1][int'(b_ra) % 25];
    a_mx <= a_clr ? {1'b1, {N-1{1'b0}}} : (a_av && a_din > a_mx) ? a_din : a_mx;
    b_mx <= b_clr ? {1'b1, {N-1{1'b0}}} : (b_av && b_din > b_mx) ? b_din : b_mx;
  end

  logic m_busy[2], m_done[2], m_rd_en[2], m_clr[2], m_av[2], m_ov[2];
  logic [9:0] m_ra[2];
  logic [7:0] m_oa[2];
  logic signed [N-1:0] m_od[2];
  always_comb begin
    m_busy[0] = a_busy;  m_busy[1] = b_busy;
    m_done[0] = a_done;  m_done[1] = b_done;
    m_rd_en[0] = a_rd_en; m_rd_en[1] = b_rd_en;
    m_clr[0] = a_clr;    m_clr[1] = b_clr;
    m_av[0] = a_av;      m_av[1] = b_av;
    m_ov[0] = a_ov;      m_ov[1] = b_ov;
    m_ra[0] = a_ra;      m_ra[1] = b_ra;
    m_oa[0] = a_oa;      m_oa[1] = b_oa;
    m_od[0] = a_od;      m_od[1] = b_od;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t0 = 0, pass_id = 0, done_rel = 33;
  bit pass_on = 0, tmode = 0, bp = 0, skip = 1, post_rst = 0, end_chk = 0, lit_on = 0;
  int ex_addr [2][16];
  int ex_data [2][4];
  int lit_addr [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int lit_d [4];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc - t0);
  endtask

  int seen_id = 0, rel;
  int ridx[2], hidx[2], dcnt[2];
  bit pv[2], pr;
  logic signed [N-1:0] pd[2];
  logic [7:0] pa[2];
  always @(negedge clk) begin
    if (pass_id != seen_id) begin
      seen_id = pass_id;
      for (int i = 0; i < 2; i++) begin ridx[i] = 0; hidx[i] = 0; dcnt[i] = 0; end
    end
    rel = cyc - t0;
    for (int i = 0; i < 2; i++) begin
      string p;
      p = i ? "b" : "a";
      if (!skip) begin
        if (m_done[i]) dcnt[i]++;
        chk({p, "_clr_valid_excl"}, m_clr[i] & m_av[i], 0);
        if (post_rst) begin
          chk({p, "_rst_ctrl"}, {m_busy[i], m_done[i], m_rd_en[i], m_clr[i], m_av[i], m_ov[i]}, 0);
          chk({p, "_rst_rd_addr"}, m_ra[i], 0);
          chk({p, "_rst_out_data"}, m_od[i], 0);
          chk({p, "_rst_out_addr"}, m_oa[i], 0);
        end else if (!pass_on)
          chk({p, "_idle_ctrl"}, {m_busy[i], m_done[i], m_rd_en[i], m_clr[i], m_av[i], m_ov[i]}, 0);
        if (pass_on) begin
          if (m_rd_en[i]) begin
            if (ridx[i] < 16) begin
              chk({p, "_rd_addr"}, m_ra[i], ex_addr[i][ridx[i]]);
              if (lit_on && i == 0) chk("a_rd_addr_lit", m_ra[i], lit_addr[ridx[i]]);
            end else chk({p, "_extra_read"}, ridx[i], 15);
            if (i == 1) chk("b_col_row_in_window", (m_ra[i] % 5 != 4) && (m_ra[i] < 20), 1);
            ridx[i]++;
          end
          if (tmode) begin
            chk({p, "_busy"}, m_busy[i], rel >= 1 && rel < done_rel);
            chk({p, "_done"}, m_done[i], rel == done_rel);
          end
          if (m_ov[i]) chk({p, "_stall_strobes"}, {m_rd_en[i], m_clr[i], m_av[i]}, 0);
          if (pv[i] && !pr) begin
            chk({p, "_hold_valid"}, m_ov[i], 1);
            chk({p, "_hold_data"}, m_od[i], pd[i]);
            chk({p, "_hold_addr"}, m_oa[i], pa[i]);
          end
          if (m_ov[i] && out_ready) begin
            if (hidx[i] < 4) begin
              chk({p, "_out_addr"}, m_oa[i], hidx[i]);
              chk({p, "_out_data"}, m_od[i], ex_data[i][hidx[i]]);
              if (lit_on && i == 0) chk("a_out_data_lit", m_od[i], lit_d[hidx[i]]);
              if (tmode) chk({p, "_emit_cycle"}, rel, 8 * (hidx[i] + 1) + ((bp && hidx[i] >= 1) ? 3 : 0));
            end else chk({p, "_extra_out"}, hidx[i], 3);
            hidx[i]++;
          end
        end
        if (end_chk) begin
          chk({p, "_read_count"}, ridx[i], 16);
          chk({p, "_out_count"}, hidx[i], 4);
          chk({p, "_done_count"}, dcnt[i], 1);
        end
      end
      pv[i] = m_ov[i] && !skip;
      pd[i] = m_od[i];
      pa[i] = m_oa[i];
    end
    pr = out_ready;
  end

  // scen: 0 ascending, 1 all-negative, 2 random data with random backpressure.
  task automatic run_pass(input int scen, input bit bp_i, input bit restart, input bit rst_mid);
    int lim;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 25; i++)
        mem[j][i] = scen == 0 ? 16'(i) : scen == 1 ? 16'(i - 16) : 16'($urandom);
    for (int j = 0; j < 2; j++) begin
      int w, mx, ad;
      w = j ? 5 : 4;
      for (int k = 0; k < 4; k++) begin
        mx = -32768;
        for (int q = 0; q < 4; q++) begin
          ad = ((k / 2) * 2 + q / 2) * w + (k % 2) * 2 + q % 2;
          ex_addr[j][k * 4 + q] = ad;
          if (int'(mem[j][ad]) > mx) mx = int'(mem[j][ad]);
        end
        ex_data[j][k] = mx;
      end
    end
    if (scen == 0) lit_d = '{5, 7, 13, 15};
    else lit_d = '{-11, -9, -3, -1};
    lit_on = scen < 2;
    tmode = scen < 2;
    bp = bp_i;
    done_rel = 33 + (bp_i ? 3 : 0);
    lim = tmode ? done_rel + 2 : 300;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    pass_id++;
    pass_on = 1;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk); #1;
      start = restart && c == 10;
      out_ready = tmode ? !(bp_i && c >= 16 && c <= 18) : ($urandom_range(0, 3) != 0);
      if (rst_mid && c == 12) begin
        reset = 1'b1; skip = 1; pass_on = 0;
        @(posedge clk); #1;
        reset = 1'b0; skip = 0; post_rst = 1; out_ready = 1'b1;
        @(posedge clk); #1;
        post_rst = 0;
        return;
      end
    end
    end_chk = 1;
    @(posedge clk); #1;
    end_chk = 0; pass_on = 0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; skip = 0; post_rst = 1;
    @(posedge clk); #1 post_rst = 0;
    run_pass(0, 0, 0, 0);
    run_pass(1, 0, 0, 0);
    run_pass(0, 1, 0, 0);
    run_pass(0, 0, 1, 0);
    run_pass(0, 0, 0, 1);
    run_pass(0, 0, 0, 0);
    repeat (3) run_pass(2, 0, 0, 0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/maxpool_ctrl.md
# maxpool_ctrl

Sequencer for the max-pooling stage. It walks a feature map stored row-major in a 1-cycle-latency buffer memory and generates one non-overlapping POOL×POOL window at a time. For each window it drives an external running-max accumulator with clear/valid strobes, and emits one pooled value per window on a valid/ready output stream. It sits between the convolution output buffer and the pooled-feature buffer; the max datapath itself stays outside this block.

## Interface
- N, 16: signed data width of pixels and of the max result.
- IMG_W, 28: input feature-map width in pixels.
- IMG_H, 28: input feature-map height in pixels.
- POOL, 2: window size and stride, POOL ≥ 2.
- ADDR_W, 10: input address width; IMG_W*IMG_H ≤ 2^ADDR_W.
- OUT_ADDR_W, 8: output address width; (IMG_W/POOL)*(IMG_H/POOL) ≤ 2^OUT_ADDR_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a full-map pass; sampled only in IDLE.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse after the last window is accepted.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  N  signed buffer data, valid the cycle after rd_en.
- acc_clr  out  1  clears the accumulator to the most-negative value.
- acc_valid  out  1  accumulator update strobe.
- acc_din  out  N  accumulator input; equals rd_data, passed through combinationally.
- acc_max  in  N  signed current accumulator max; reflects an update one cycle after acc_valid.
- out_valid  out  1  pooled result available.
- out_ready  in  1  downstream accepts the result when high together with out_valid.
- out_data  out  N  signed pooled max.
- out_addr  out  OUT_ADDR_W  pooled index, wy*OUT_W + wx.

## Operation
- OUT_W = IMG_W/POOL and OUT_H = IMG_H/POOL, both floored. Trailing columns and rows that do not fill a window are never read.
- Windows are processed in raster order (wx fastest, then wy).
- Inside a window, reads go in raster order (dx fastest, then dy).
- Read address: rd_addr = (wy*POOL+dy)*IMG_W + wx*POOL + dx.
- FSM states: IDLE, CLR, READ, WAIT1, WAIT2, EMIT, DONE.
  - IDLE: all strobes low. If start=1, clear the window counters and go to CLR.
  - CLR: acc_clr=1 for one cycle, then go to READ.
  - READ: POOL*POOL cycles with rd_en=1, stepping dx/dy, then go to WAIT1.
  - WAIT1: the last read's data is in flight; no new read.
  - WAIT2: capture acc_max into out_data and latch out_addr.
  - EMIT: out_valid=1. On out_ready=1, either go to CLR for the next window, or go to DONE if this was the last window.
  - DONE: done=1 for one cycle, then go to IDLE.
- acc_valid is rd_en delayed one cycle through a register. acc_valid is therefore high during READ cycles 2..P² and in WAIT1.
- acc_clr and acc_valid are never high in the same cycle.
- busy=1 in CLR, READ, WAIT1, WAIT2 and EMIT. busy=0 in IDLE and DONE.
- start is ignored in every state other than IDLE.
- No arithmetic on data in this block. All counters are unsigned and sized from the parameters.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, acc_clr=0, acc_valid=0, out_valid=0, out_data=0, out_addr=0. State = IDLE.
- Reset mid-pass aborts immediately with no done pulse. The next pass still starts correctly because every window begins with CLR.
- start sampled high at edge t puts the block in CLR during cycle t+1.
- Cycles per window with out_ready held high: 1 + P² + 2 + 1, which is 8 for POOL=2.
- Pass length from start: OUT_W*OUT_H*(P²+4) cycles to the last EMIT. done follows one cycle later.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_addr stay stable. During this time rd_en=0, acc_valid=0 and acc_clr=0.
- out_valid drops in the cycle after the handshake.

## Test plan
- **Ascending map.** IMG_W=IMG_H=4, POOL=2, mem[i]=i, out_ready=1, start pulsed at cycle 0.
  - rd_addr sequence: 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
  - Outputs (addr:data): 0:5, 1:7, 2:13, 3:15, with EMIT at cycles 8, 16, 24, 32.
  - done high at cycle 33 only.
- **All-negative map.** mem[i]=i-16 on the same geometry. Outputs: -11, -9, -3, -1.
  - Proves acc_clr precedes each window, so no value carries over between windows.
- **Backpressure.** out_ready low for 3 cycles at window 1's EMIT.
  - out_data=7 and out_addr=1 held; no rd_en, acc_valid or acc_clr during the stall.
  - Each subsequent EMIT shifts 3 cycles later.
- **Odd geometry.** IMG_W=IMG_H=5, POOL=2.
  - Exactly 4 outputs.
  - No rd_addr with column 4 or row 4 (addresses 4, 9, 14, 19, 20–24 never issued).
- **Start while busy.** Pulse start again at cycle 10: ignored; the pass completes normally with a single done pulse.
- **Reset mid-pass.** Assert reset at cycle 12.
  - All outputs return to reset values the next cycle; no done pulse.
  - A fresh start reproduces the ascending-map results exactly.
